// File: rtl/sfa_bram_pkg.sv
// Shared definitions for the sfa BRAM responder: FSM encodings, preload counter width
// and the address fault check.
package sfa_bram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RDBACK = 2'd2
    } ld_state_t;

    localparam int LD_COUNT_W = 16;

    // Returns {misaligned, out_of_range} for a byte address into a 2**aw word array.
    function automatic logic [1:0] addr_fault(input logic [31:0] addr, input int unsigned aw);
        logic [31:0] hi;
        hi = addr >> (aw + 2);
        return {|addr[1:0], |hi};
    endfunction

endpackage

// File: rtl/sfa_bram_array.sv
// Byte-enabled 32-bit word array: one muxed write port (BRAM side wins over preload)
// and one read port with READ_LAT 0 (combinational) or 1 (registered).
module sfa_bram_array
    import sfa_bram_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 0
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              bram_rst,
    input  logic              bram_en,
    input  logic              in_range,
    input  logic [3:0]        bram_we,
    input  logic [ADDR_W-1:0] bram_idx,
    input  logic [31:0]       bram_din,
    input  logic              ld_wen,
    input  logic [ADDR_W-1:0] ld_idx,
    input  logic [31:0]       ld_data,
`ifdef SFA_BRAM_RDBACK_EN
    input  logic [ADDR_W-1:0] rb_idx,
    output logic [31:0]       rb_data,
`endif
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic              bram_wsel;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    // An out-of-range BRAM write still owns the port for that cycle; it just writes nothing.
    always_comb begin
        bram_wsel = bram_en & (|bram_we);
        wr_idx    = ld_idx;
        wr_data   = ld_data;
        wr_be     = {4{ld_wen}};
        if (bram_wsel) begin
            wr_idx  = bram_idx;
            wr_data = bram_din;
            wr_be   = in_range ? bram_we : 4'b0000;
        end
    end

    always_ff @(posedge ACLK) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    generate
        if (READ_LAT == 0) begin : g_rd_comb
            logic unused_rst;
            assign unused_rst = ARESETN ^ bram_rst;
            assign rd_data    = (bram_en && in_range) ? mem[bram_idx] : 32'h0;
        end else begin : g_rd_reg
            logic [31:0] dout_p1;
            // Stage p1: read-before-write, holds while bram_en is low.
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN)      dout_p1 <= 32'h0;
                else if (bram_rst) dout_p1 <= 32'h0;
                else if (bram_en)  dout_p1 <= in_range ? mem[bram_idx] : 32'h0;
            end
            assign rd_data = dout_p1;
        end
    endgenerate

`ifdef SFA_BRAM_RDBACK_EN
    assign rb_data = mem[rb_idx];
`endif

endmodule

// File: rtl/sfa_bram_resp.sv
// Responder side of the sfa BRAM port with AXI-Stream preload and address fault flag.
// Optional full-array readback stream when SFA_BRAM_RDBACK_EN is defined.
module sfa_bram_resp
    import sfa_bram_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  bram_clk,
    input  logic                  bram_rst,
    input  logic                  bram_en,
    input  logic [3:0]            bram_we,
    input  logic [31:0]           bram_addr,
    input  logic [31:0]           bram_din,
    output logic [31:0]           bram_dout,
    output logic                  sLD_tready,
    input  logic                  sLD_tvalid,
    input  logic [31:0]           sLD_tdata,
    input  logic                  sLD_tlast,
    input  logic                  LD_START,
    input  logic [ADDR_W-1:0]     LD_BASE,
    output logic                  LD_BUSY,
    output logic                  LD_DONE,
    output logic [LD_COUNT_W-1:0] LD_COUNT,
    input  logic                  ERR_CLR,
`ifdef SFA_BRAM_RDBACK_EN
    input  logic                  RB_START,
    input  logic                  mRB_tready,
    output logic                  mRB_tvalid,
    output logic [31:0]           mRB_tdata,
    output logic                  mRB_tlast,
`endif
    output logic                  ADDR_ERR
);

    ld_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        fault;
    logic              in_range;
    logic [ADDR_W-1:0] bram_idx;
    logic              ld_wen;
    logic              unused_bram_clk;

    assign unused_bram_clk = bram_clk;
    assign fault    = addr_fault(bram_addr, ADDR_W);
    assign in_range = ~fault[0];
    assign bram_idx = bram_addr[ADDR_W+1:2];

    // The BRAM write port has priority; the preload stream stalls for that cycle.
    assign sLD_tready = (state == LOAD) & ~(bram_en & (|bram_we));
    assign ld_wen     = sLD_tvalid & sLD_tready;

`ifdef SFA_BRAM_RDBACK_EN
    logic [ADDR_W-1:0] rb_ptr;
    logic [31:0]       rb_data;
`endif

    sfa_bram_array #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) u_array (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .bram_rst (bram_rst),
        .bram_en  (bram_en),
        .in_range (in_range),
        .bram_we  (bram_we),
        .bram_idx (bram_idx),
        .bram_din (bram_din),
        .ld_wen   (ld_wen),
        .ld_idx   (ptr),
        .ld_data  (sLD_tdata),
`ifdef SFA_BRAM_RDBACK_EN
        .rb_idx   (rb_ptr),
        .rb_data  (rb_data),
`endif
        .rd_data  (bram_dout)
    );

    // Set wins over clear when a fault coincides with ERR_CLR or bram_rst.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                   ADDR_ERR <= 1'b0;
        else if (bram_en && (|fault))   ADDR_ERR <= 1'b1;
        else if (ERR_CLR || bram_rst)   ADDR_ERR <= 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            ptr      <= '0;
            LD_BUSY  <= 1'b0;
            LD_DONE  <= 1'b0;
            LD_COUNT <= '0;
`ifdef SFA_BRAM_RDBACK_EN
            rb_ptr     <= '0;
            mRB_tvalid <= 1'b0;
            mRB_tdata  <= 32'h0;
            mRB_tlast  <= 1'b0;
`endif
        end else begin
            LD_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (LD_START) begin
                        state    <= LOAD;
                        ptr      <= LD_BASE;
                        LD_COUNT <= '0;
                        LD_BUSY  <= 1'b1;
                    end
`ifdef SFA_BRAM_RDBACK_EN
                    else if (RB_START) begin
                        state      <= RDBACK;
                        rb_ptr     <= '0;
                        mRB_tvalid <= 1'b0;
                        mRB_tlast  <= 1'b0;
                    end
`endif
                end
                LOAD: begin
                    if (ld_wen) begin
                        ptr <= ptr + 1'b1;
                        if (LD_COUNT != {LD_COUNT_W{1'b1}}) LD_COUNT <= LD_COUNT + 1'b1;
                        if (sLD_tlast) begin
                            state   <= IDLE;
                            LD_BUSY <= 1'b0;
                            LD_DONE <= 1'b1;
                        end
                    end
                end
`ifdef SFA_BRAM_RDBACK_EN
                // Output word is registered so it stays stable while the sink stalls.
                RDBACK: begin
                    if (!mRB_tvalid || mRB_tready) begin
                        if (mRB_tvalid && mRB_tlast) begin
                            mRB_tvalid <= 1'b0;
                            mRB_tlast  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            mRB_tvalid <= 1'b1;
                            mRB_tdata  <= rb_data;
                            mRB_tlast  <= (rb_ptr == {ADDR_W{1'b1}});
                            rb_ptr     <= rb_ptr + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfa_bram_resp.sv
// Directed bench for sfa_bram_resp: one instance per READ_LAT setting on shared inputs.
// Readback scenario is built only when SFA_BRAM_RDBACK_EN is defined.
module tb_sfa_bram_resp;

    localparam int ADDR_W = 10;

    logic              ACLK, ARESETN, bram_rst, bram_en;
    logic [3:0]        bram_we;
    logic [31:0]       bram_addr, bram_din;
    logic              sLD_tvalid, sLD_tlast, LD_START, ERR_CLR;
    logic [31:0]       sLD_tdata;
    logic [ADDR_W-1:0] LD_BASE;

    logic [31:0] dout0, dout1;
    logic        tready0, tready1, busy0, busy1, done0, done1, err0, err1;
    logic [15:0] cnt0, cnt1;

`ifdef SFA_BRAM_RDBACK_EN
    logic        RB_START, mRB_tready;
    logic        rb_tvalid0, rb_tlast0, rb_tvalid1, rb_tlast1;
    logic [31:0] rb_tdata0, rb_tdata1;
`endif

    int nchk = 0;
    int nerr = 0;

    sfa_bram_resp #(.ADDR_W(ADDR_W), .READ_LAT(0)) dut0 (
        .ACLK(ACLK), .ARESETN(ARESETN), .bram_clk(ACLK), .bram_rst(bram_rst),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(dout0), .sLD_tready(tready0), .sLD_tvalid(sLD_tvalid),
        .sLD_tdata(sLD_tdata), .sLD_tlast(sLD_tlast), .LD_START(LD_START), .LD_BASE(LD_BASE),
        .LD_BUSY(busy0), .LD_DONE(done0), .LD_COUNT(cnt0), .ERR_CLR(ERR_CLR),
`ifdef SFA_BRAM_RDBACK_EN
        .RB_START(RB_START), .mRB_tready(mRB_tready), .mRB_tvalid(rb_tvalid0),
        .mRB_tdata(rb_tdata0), .mRB_tlast(rb_tlast0),
`endif
        .ADDR_ERR(err0)
    );

    sfa_bram_resp #(.ADDR_W(ADDR_W), .READ_LAT(1)) dut1 (
        .ACLK(ACLK), .ARESETN(ARESETN), .bram_clk(ACLK), .bram_rst(bram_rst),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(dout1), .sLD_tready(tready1), .sLD_tvalid(sLD_tvalid),
        .sLD_tdata(sLD_tdata), .sLD_tlast(sLD_tlast), .LD_START(LD_START), .LD_BASE(LD_BASE),
        .LD_BUSY(busy1), .LD_DONE(done1), .LD_COUNT(cnt1), .ERR_CLR(ERR_CLR),
`ifdef SFA_BRAM_RDBACK_EN
        .RB_START(RB_START), .mRB_tready(mRB_tready), .mRB_tvalid(rb_tvalid1),
        .mRB_tdata(rb_tdata1), .mRB_tlast(rb_tlast1),
`endif
        .ADDR_ERR(err1)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; bram_rst = 1'b0; bram_en = 1'b0; bram_we = 4'h0;
        bram_addr = 32'h0; bram_din = 32'h0; sLD_tvalid = 1'b0; sLD_tdata = 32'h0;
        sLD_tlast = 1'b0; LD_START = 1'b0; LD_BASE = '0; ERR_CLR = 1'b0;
`ifdef SFA_BRAM_RDBACK_EN
        RB_START = 1'b0; mRB_tready = 1'b0;
`endif
        tick(); tick();
        nchk++;
        if ({dout0, dout1} !== 64'h0) begin
            nerr++; $display("FAIL reset_dout: got %h/%h expected 0/0", dout0, dout1);
        end
        nchk++;
        if ({tready0, tready1, busy0, busy1, done0, done1, err0, err1} !== 8'h0) begin
            nerr++;
            $display("FAIL reset_ctrl: got tready=%b%b busy=%b%b done=%b%b err=%b%b expected all 0",
                     tready0, tready1, busy0, busy1, done0, done1, err0, err1);
        end
        nchk++;
        if ({cnt0, cnt1} !== 32'h0) begin
            nerr++; $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt0, cnt1);
        end
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        bram_en = 1'b1; bram_we = 4'hF; bram_addr = 32'h10; bram_din = 32'hDEADBEEF;
        tick();
        bram_we = 4'h0; #1;
        nchk++;
        if (dout0 !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL wr_rd_lat0: got %h expected deadbeef", dout0);
        end
        tick();
        nchk++;
        if (dout1 !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL wr_rd_lat1: got %h expected deadbeef", dout1);
        end
        // Overwrite the same word while reading it.
        bram_we = 4'hF; bram_din = 32'h01020304; #1;
        nchk++;
        if (dout0 !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL rdw_lat0_before: got %h expected deadbeef", dout0);
        end
        tick();
        nchk++;
        if (dout1 !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL rdw_lat1_old: got %h expected deadbeef", dout1);
        end
        bram_we = 4'h0; #1;
        nchk++;
        if (dout0 !== 32'h01020304) begin
            nerr++; $display("FAIL rdw_lat0_after: got %h expected 01020304", dout0);
        end
        tick();
        bram_en = 1'b0; #1;
        nchk++;
        if (dout0 !== 32'h0) begin
            nerr++; $display("FAIL idle_lat0: got %h expected 0", dout0);
        end
        tick();
        nchk++;
        if (dout1 !== 32'h01020304) begin
            nerr++; $display("FAIL hold_lat1: got %h expected 01020304", dout1);
        end
    endtask

    task automatic test_byte_write();
        bram_en = 1'b1; bram_we = 4'hF; bram_addr = 32'h20; bram_din = 32'h11223344;
        tick();
        bram_we = 4'b0101; bram_din = 32'hAABBCCDD;
        tick();
        bram_we = 4'h0; #1;
        nchk++;
        if (dout0 !== 32'h11BB33DD) begin
            nerr++; $display("FAIL byte_we_lat0: got %h expected 11bb33dd", dout0);
        end
        tick();
        nchk++;
        if (dout1 !== 32'h11BB33DD) begin
            nerr++; $display("FAIL byte_we_lat1: got %h expected 11bb33dd", dout1);
        end
        bram_en = 1'b0;
    endtask

    task automatic test_faults();
        bram_en = 1'b1; bram_we = 4'h0; bram_addr = 32'h1000; #1;
        nchk++;
        if (dout0 !== 32'h0) begin
            nerr++; $display("FAIL oor_rd_lat0: got %h expected 0", dout0);
        end
        tick();
        nchk++;
        if (dout1 !== 32'h0 || err0 !== 1'b1 || err1 !== 1'b1) begin
            nerr++; $display("FAIL oor_rd_err: got dout1=%h err=%b%b expected 0, 11", dout1, err0, err1);
        end
        bram_we = 4'hF; bram_addr = 32'h22; bram_din = 32'hCAFEF00D;
        tick();
        bram_we = 4'h0; bram_addr = 32'h20; #1;
        nchk++;
        if (dout0 !== 32'hCAFEF00D || err0 !== 1'b1) begin
            nerr++; $display("FAIL misalign_wr: got %h err=%b expected cafef00d err=1", dout0, err0);
        end
        bram_we = 4'hF; bram_addr = 32'h1020; bram_din = 32'h0BADBAD0;
        tick();
        bram_we = 4'h0; bram_addr = 32'h20; #1;
        nchk++;
        if (dout0 !== 32'hCAFEF00D) begin
            nerr++; $display("FAIL oor_wr_dropped: got %h expected cafef00d", dout0);
        end
        bram_en = 1'b0; ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        nchk++;
        if (err0 !== 1'b0 || err1 !== 1'b0) begin
            nerr++; $display("FAIL err_clr: got %b%b expected 00", err0, err1);
        end
        ERR_CLR = 1'b1; bram_en = 1'b1; bram_addr = 32'h1001;
        tick();
        nchk++;
        if (err0 !== 1'b1) begin
            nerr++; $display("FAIL err_set_wins: got %b expected 1", err0);
        end
        ERR_CLR = 1'b0; bram_addr = 32'h20;
        tick();
        bram_en = 1'b0; bram_rst = 1'b1;
        nchk++;
        if (dout1 !== 32'hCAFEF00D) begin
            nerr++; $display("FAIL pre_rst_lat1: got %h expected cafef00d", dout1);
        end
        tick();
        bram_rst = 1'b0;
        nchk++;
        if (err0 !== 1'b0 || dout1 !== 32'h0) begin
            nerr++; $display("FAIL bram_rst_clr: got err=%b dout1=%h expected 0, 0", err0, dout1);
        end
    endtask

    task automatic test_preload_wrap();
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        addrs = '{32'hFF8, 32'hFFC, 32'h000, 32'h004, 32'h040};
        exps  = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h55};
        LD_BASE = 10'd1022; LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        nchk++;
        if (busy0 !== 1'b1 || tready0 !== 1'b1) begin
            nerr++; $display("FAIL ld_enter: got busy=%b tready=%b expected 1 1", busy0, tready0);
        end
        sLD_tvalid = 1'b1; sLD_tdata = 32'd1; sLD_tlast = 1'b0;
        tick();
        sLD_tdata = 32'd2; bram_en = 1'b1; bram_we = 4'hF; bram_addr = 32'h40; bram_din = 32'h55; #1;
        nchk++;
        if (tready0 !== 1'b0) begin
            nerr++; $display("FAIL ld_collide_stall: got tready=%b expected 0", tready0);
        end
        tick();
        bram_en = 1'b0; bram_we = 4'h0; #1;
        nchk++;
        if (tready0 !== 1'b1 || cnt0 !== 16'd1) begin
            nerr++; $display("FAIL ld_resume: got tready=%b count=%0d expected 1 1", tready0, cnt0);
        end
        tick();
        sLD_tdata = 32'd3;
        tick();
        sLD_tdata = 32'd4; sLD_tlast = 1'b1;
        nchk++;
        if (done0 !== 1'b0) begin
            nerr++; $display("FAIL ld_done_early: got %b expected 0", done0);
        end
        tick();
        sLD_tvalid = 1'b0; sLD_tlast = 1'b0;
        nchk++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 16'd4 || tready0 !== 1'b0) begin
            nerr++;
            $display("FAIL ld_finish: got done=%b busy=%b count=%0d tready=%b expected 1 0 4 0",
                     done0, busy0, cnt0, tready0);
        end
        tick();
        nchk++;
        if (done0 !== 1'b0) begin
            nerr++; $display("FAIL ld_done_pulse: got %b expected 0", done0);
        end
        for (int i = 0; i < 5; i++) begin
            bram_en = 1'b1; bram_addr = addrs[i]; #1;
            nchk++;
            if (dout0 !== exps[i]) begin
                nerr++; $display("FAIL ld_word%0d_lat0: got %h expected %h", i, dout0, exps[i]);
            end
            tick();
            nchk++;
            if (dout1 !== exps[i]) begin
                nerr++; $display("FAIL ld_word%0d_lat1: got %h expected %h", i, dout1, exps[i]);
            end
        end
        bram_en = 1'b0;
    endtask

    task automatic test_reset_mid_preload();
        LD_BASE = 10'd100; LD_START = 1'b1;
        tick();
        LD_START = 1'b0; sLD_tvalid = 1'b1; sLD_tdata = 32'hA1;
        tick();
        sLD_tdata = 32'hA2;
        tick();
        sLD_tdata = 32'hA3; ARESETN = 1'b0; #1;
        sLD_tvalid = 1'b0;
        nchk++;
        if (busy0 !== 1'b0 || cnt0 !== 16'd0 || done0 !== 1'b0 || tready0 !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_ld: got busy=%b count=%0d done=%b tready=%b expected 0 0 0 0",
                     busy0, cnt0, done0, tready0);
        end
        tick();
        ARESETN = 1'b1;
        tick();
        nchk++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_no_done: got done=%b busy=%b expected 0 0", done0, busy0);
        end
        bram_en = 1'b1; bram_addr = 32'd400; #1;
        nchk++;
        if (dout0 !== 32'hA1) begin
            nerr++; $display("FAIL rst_mid_kept0: got %h expected a1", dout0);
        end
        bram_addr = 32'd404; #1;
        nchk++;
        if (dout0 !== 32'hA2) begin
            nerr++; $display("FAIL rst_mid_kept1: got %h expected a2", dout0);
        end
        bram_en = 1'b0;
        tick();
    endtask

`ifdef SFA_BRAM_RDBACK_EN
    task automatic test_readback();
        int          idx;
        logic        held_v;
        logic [31:0] held;
        LD_BASE = '0; LD_START = 1'b1;
        tick();
        LD_START = 1'b0; sLD_tvalid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            sLD_tdata = 32'(i); sLD_tlast = (i == 1023);
            tick();
        end
        sLD_tvalid = 1'b0; sLD_tlast = 1'b0;
        nchk++;
        if (done0 !== 1'b1 || cnt0 !== 16'd1024) begin
            nerr++; $display("FAIL rb_preload: got done=%b count=%0d expected 1 1024", done0, cnt0);
        end
        RB_START = 1'b1;
        tick();
        RB_START = 1'b0;
        idx = 0; held_v = 1'b0; held = 32'h0;
        for (int c = 0; c < 6000 && idx < 1024; c++) begin
            mRB_tready = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            if (rb_tvalid0) begin
                if (held_v) begin
                    nchk++;
                    if (rb_tdata0 !== held) begin
                        nerr++; $display("FAIL rb_stable: got %h expected %h", rb_tdata0, held);
                    end
                end
                if (mRB_tready) begin
                    nchk++;
                    if (rb_tdata0 !== 32'(idx) || rb_tlast0 !== (idx == 1023)) begin
                        nerr++;
                        $display("FAIL rb_beat%0d: got data=%h last=%b expected %h %b",
                                 idx, rb_tdata0, rb_tlast0, 32'(idx), (idx == 1023));
                    end
                    idx++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held   = rb_tdata0;
                end
            end
            tick();
        end
        mRB_tready = 1'b0;
        nchk++;
        if (idx != 1024 || rb_tvalid0 !== 1'b0) begin
            nerr++; $display("FAIL rb_complete: got beats=%0d tvalid=%b expected 1024 0", idx, rb_tvalid0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_faults();
        test_preload_wrap();
        test_reset_mid_preload();
`ifdef SFA_BRAM_RDBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
